rtdf_sample_unpacker: RTL and testbench
=======================================

Name: rtdf_sample_unpacker

Overview:
Parametrised word-to-sample gearbox for the real-time data feed. It consumes fixed-width words from a show-ahead packet FIFO and emits one SAMPLE_W-bit sample per clock, carrying leftover bits across word boundaries. It is the successor of the fixed 16b to 3b sample generator, adding configurable widths, bit order, flush, and underrun/sample statistics. It sits between rtdf_packet_processor's read side and the tracking-channel sample input.

Parameters:
WORD_W, 16, input word width in bits (8..32)
SAMPLE_W, 3, output sample width in bits (1..8, SAMPLE_W <= WORD_W)
MSB_FIRST, 0, 0: bit 0 of each word is earliest and lands in sample bit 0; 1: bit WORD_W-1 is earliest and lands in sample MSB
CNT_W, 32, width of sample_count

Ports:
clk  in  1  sample clock, all logic on rising edge
reset  in  1  synchronous, active-high
word_valid  in  1  FIFO not empty; word_data valid (show-ahead)
word_data  in  WORD_W  current FIFO head word
word_rd  out  1  combinational pop strobe to FIFO
flush  in  1  discard all buffered bits this cycle
halt  in  1  freeze all state
sample_valid  out  1  registered; sample_data valid
sample_data  out  SAMPLE_W  registered sample
fill_level  out  clog2(BUF_W+1)  buffered bit count
sample_count  out  CNT_W  samples emitted since reset, wraps
underrun_count  out  16  starved cycles, saturating at 16'hFFFF

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- localparam BUF_W = WORD_W + 2*SAMPLE_W. Internal bit buffer buf[BUF_W-1:0], fill count fill, flag started.
- Reset: buf, fill, started, sample_data, sample_count, underrun_count all 0; sample_valid 0. word_rd is 0 during reset.
- pop = !reset && !halt && !flush && fill >= SAMPLE_W.
- fill_ap = fill - (pop ? SAMPLE_W : 0).
- push = word_rd = !reset && !halt && !flush && word_valid && fill_ap + WORD_W <= BUF_W.
- Per cycle:
  - The sample is buf[SAMPLE_W-1:0].
  - On pop, buf shifts right by SAMPLE_W.
  - On push, the ingest word is written at bit offset fill_ap.
  - fill <= fill_ap + (push ? WORD_W : 0).
  - Push and pop in the same cycle are legal and required for full rate.
- Ingest word: word_data if MSB_FIRST=0, else bit-reversed word_data. Emitted sample: buf[SAMPLE_W-1:0] if MSB_FIRST=0, else its bit reverse.
- Output latency: sample_valid/sample_data register pop and the sample one cycle after the pop cycle. sample_data holds its last value when sample_valid=0.
- sample_count increments on each pop. started is set on the first pop.
- underrun_count increments (saturating) on cycles with !halt && !flush && started && !pop.
- halt: no push, no pop, no counter change. sample_valid is 0 on the next cycle; buf and fill are held.
- flush: fill <= 0, started <= 0, no word consumed, sample_valid 0 next cycle. flush beats push and pop; halt=1 suppresses flush. Counters are not cleared.
- Throughput: with word_valid held high, sample_valid is continuous after the first word. Average word_rd rate is SAMPLE_W/WORD_W.
- Invariant: fill <= BUF_W at all times; overflow is unreachable by construction, so no overflow handling is required.
- word_data is sampled only on the cycle when word_rd=1. The upstream FIFO advances after that edge.

Decomposition:
- Package rtdf_pkg: default WORD_W/SAMPLE_W constants, clog2 function, BUF_W derivation.
- One sub-module: rtdf_bit_reverse (parameter WIDTH, combinational). It is instantiated twice: ingest word and output sample. Pass-through when MSB_FIRST=0.
- Everything else is flat in rtdf_sample_unpacker.

Test Plan:
1. SAMPLE_W=4, MSB_FIRST=0, single word 16'h1234 -> samples 4,3,2,1 on consecutive cycles; sample_count=4; underrun_count then increments by 1 per cycle.
2. SAMPLE_W=4, MSB_FIRST=1, single word 16'h1234 -> samples 1,2,3,4.
3. SAMPLE_W=3, three words 16'hFFFF back-to-back -> 16 consecutive samples of 3'd7; fill_level returns to 0; word_rd asserted exactly 3 times.
4. SAMPLE_W=4, word 16'h1234, flush after 2 samples, then word 16'hABCD -> samples 4,3, then D,C,B,A; 16'h12 bits are never emitted; underrun_count does not increment between flush and the next pop.
5. SAMPLE_W=3, continuous word_valid, halt high for 5 cycles mid-stream -> sample_valid low for those 5 cycles, no word_rd, fill_level constant; the sample sequence after release is unbroken.
6. Reset asserted mid-stream with fill=7 -> next cycle fill_level=0, sample_valid=0, counters=0, word_rd=0 while reset is high.

Source files
------------

// File: rtl/rtdf_pkg.sv
// Shared constants and helpers for the real-time data feed sample path.
// Buffer sizing is derived here so the top and its users agree on widths.
package rtdf_pkg;

   localparam int WORD_W_DEF   = 16;
   localparam int SAMPLE_W_DEF = 3;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   // Room for one word plus up to two samples of leftover bits.
   function automatic int buf_w(input int ww, input int sw);
      return ww + 2 * sw;
   endfunction

endpackage

// File: rtl/rtdf_bit_reverse.sv
// Optional bit reversal of a vector; plain pass-through when disabled.
module rtdf_bit_reverse #(
   parameter int WIDTH  = 8,
   parameter bit ENABLE = 1'b0
) (
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign data_o[i] = ENABLE ? data_i[WIDTH-1-i] : data_i[i];
   end

endmodule

// File: rtl/rtdf_sample_unpacker.sv
// Word-to-sample gearbox: pops SAMPLE_W bits per clock from a bit buffer
// refilled with whole FIFO words, carrying leftovers across word boundaries.
module rtdf_sample_unpacker
   import rtdf_pkg::*;
#(
   parameter int WORD_W    = WORD_W_DEF,
   parameter int SAMPLE_W  = SAMPLE_W_DEF,
   parameter bit MSB_FIRST = 1'b0,
   parameter int CNT_W     = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                word_valid,
   input  logic [WORD_W-1:0]   word_data,
   output logic                word_rd,
   input  logic                flush,
   input  logic                halt,
   output logic                sample_valid,
   output logic [SAMPLE_W-1:0] sample_data,
   output logic [clog2(buf_w(WORD_W, SAMPLE_W)+1)-1:0] fill_level,
   output logic [CNT_W-1:0]    sample_count,
   output logic [15:0]         underrun_count
);

   localparam int BUF_W = buf_w(WORD_W, SAMPLE_W);
   localparam int FW    = clog2(BUF_W + 1);

   localparam logic [FW-1:0] SW_F  = FW'(SAMPLE_W);
   localparam logic [FW-1:0] WW_F  = FW'(WORD_W);
   localparam logic [FW-1:0] LIM_F = FW'(BUF_W - WORD_W);

   logic [BUF_W-1:0]    bits_q, bits_d;
   logic [FW-1:0]       fill_q, fill_d, fill_ap;
   logic                started_q, started_d;
   logic                sv_q, sv_d;
   logic [SAMPLE_W-1:0] sd_q, sd_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [15:0]         und_q, und_d;

   logic                active, pop, push;
   logic [WORD_W-1:0]   ingest;
   logic [SAMPLE_W-1:0] sample;

   rtdf_bit_reverse #(.WIDTH(WORD_W), .ENABLE(MSB_FIRST)) u_rev_word (
      .data_i (word_data),
      .data_o (ingest)
   );

   rtdf_bit_reverse #(.WIDTH(SAMPLE_W), .ENABLE(MSB_FIRST)) u_rev_smp (
      .data_i (bits_q[SAMPLE_W-1:0]),
      .data_o (sample)
   );

   assign active  = !reset && !halt && !flush;
   assign pop     = active && (fill_q >= SW_F);
   assign fill_ap = pop ? fill_q - SW_F : fill_q;
   // Space check is on the post-pop fill so push and pop can share a cycle.
   assign push    = active && word_valid && (fill_ap <= LIM_F);
   assign word_rd = push;

   always_comb begin
      bits_d    = bits_q;
      fill_d    = fill_q;
      started_d = started_q;
      sv_d      = 1'b0;
      sd_d      = sd_q;
      cnt_d     = cnt_q;
      und_d     = und_q;
      if (!halt && flush) begin
         bits_d    = '0;
         fill_d    = '0;
         started_d = 1'b0;
      end else if (!halt) begin
         if (pop) begin
            bits_d    = bits_q >> SAMPLE_W;
            started_d = 1'b1;
            sv_d      = 1'b1;
            sd_d      = sample;
            cnt_d     = cnt_q + CNT_W'(1);
         end else if (started_q && und_q != 16'hFFFF) begin
            und_d = und_q + 16'd1;
         end
         if (push)
            bits_d = bits_d | ({{(BUF_W-WORD_W){1'b0}}, ingest} << fill_ap);
         fill_d = fill_ap + (push ? WW_F : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bits_q    <= '0;
         fill_q    <= '0;
         started_q <= 1'b0;
         sv_q      <= 1'b0;
         sd_q      <= '0;
         cnt_q     <= '0;
         und_q     <= '0;
      end else begin
         bits_q    <= bits_d;
         fill_q    <= fill_d;
         started_q <= started_d;
         sv_q      <= sv_d;
         sd_q      <= sd_d;
         cnt_q     <= cnt_d;
         und_q     <= und_d;
      end
   end

   assign sample_valid   = sv_q;
   assign sample_data    = sd_q;
   assign fill_level     = fill_q;
   assign sample_count   = cnt_q;
   assign underrun_count = und_q;

endmodule

// File: tb/tb_rtdf_sample_unpacker.sv
// Bench for the sample unpacker: three configurations share one stimulus
// stream, each checked every cycle against a bit-FIFO reference model.
module tb_rtdf_sample_unpacker;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        word_valid = 1'b0;
   logic [15:0] word_data = '0;
   logic        flush = 1'b0;
   logic        halt = 1'b0;

   logic        rd_a, rd_b, rd_c;
   logic        sv_a, sv_b, sv_c;
   logic [3:0]  sd_a, sd_b;
   logic [2:0]  sd_c;
   logic [4:0]  fl_a, fl_b, fl_c;
   logic [31:0] sc_a, sc_b, sc_c;
   logic [15:0] uc_a, uc_b, uc_c;

   always #5 clk = ~clk;

   rtdf_sample_unpacker #(.WORD_W(16), .SAMPLE_W(4), .MSB_FIRST(1'b0), .CNT_W(32)) u_a (
      .clk(clk), .reset(reset), .word_valid(word_valid), .word_data(word_data),
      .word_rd(rd_a), .flush(flush), .halt(halt), .sample_valid(sv_a),
      .sample_data(sd_a), .fill_level(fl_a), .sample_count(sc_a),
      .underrun_count(uc_a));

   rtdf_sample_unpacker #(.WORD_W(16), .SAMPLE_W(4), .MSB_FIRST(1'b1), .CNT_W(32)) u_b (
      .clk(clk), .reset(reset), .word_valid(word_valid), .word_data(word_data),
      .word_rd(rd_b), .flush(flush), .halt(halt), .sample_valid(sv_b),
      .sample_data(sd_b), .fill_level(fl_b), .sample_count(sc_b),
      .underrun_count(uc_b));

   rtdf_sample_unpacker #(.WORD_W(16), .SAMPLE_W(3), .MSB_FIRST(1'b0), .CNT_W(32)) u_c (
      .clk(clk), .reset(reset), .word_valid(word_valid), .word_data(word_data),
      .word_rd(rd_c), .flush(flush), .halt(halt), .sample_valid(sv_c),
      .sample_data(sd_c), .fill_level(fl_c), .sample_count(sc_c),
      .underrun_count(uc_c));

   logic        rdv [3];
   logic        svv [3];
   logic [7:0]  sdv [3];
   logic [7:0]  flv [3];
   logic [31:0] scv [3];
   logic [15:0] ucv [3];

   assign rdv[0] = rd_a;  assign rdv[1] = rd_b;  assign rdv[2] = rd_c;
   assign svv[0] = sv_a;  assign svv[1] = sv_b;  assign svv[2] = sv_c;
   assign sdv[0] = {4'b0, sd_a};
   assign sdv[1] = {4'b0, sd_b};
   assign sdv[2] = {5'b0, sd_c};
   assign flv[0] = {3'b0, fl_a};
   assign flv[1] = {3'b0, fl_b};
   assign flv[2] = {3'b0, fl_c};
   assign scv[0] = sc_a;  assign scv[1] = sc_b;  assign scv[2] = sc_c;
   assign ucv[0] = uc_a;  assign ucv[1] = uc_b;  assign ucv[2] = uc_c;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference model: an ordered list of pending bits per configuration.
   string  nm [3] = '{"A", "B", "C"};
   int     ms [3] = '{4, 4, 3};
   bit     mm [3] = '{1'b0, 1'b1, 1'b0};
   bit     mb [3][64];
   int     mn [3];
   int     mund [3];
   int     mdat [3];
   longint mcnt [3];
   bit     mst [3];
   bit     mval [3];
   int     mrd_c;

   int cyc;
   int rd_c_seen;
   int logA [$];
   int logB [$];
   int logC [$];
   int ccyc [$];

   task automatic model_cycle(input int k);
      int s, v;
      bit pop, push;
      s = ms[k];
      push = 1'b0;
      if (reset) begin
         mn[k] = 0; mst[k] = 0; mcnt[k] = 0; mund[k] = 0;
         mval[k] = 0; mdat[k] = 0;
      end else if (halt) begin
         mval[k] = 0;
      end else if (flush) begin
         mn[k] = 0; mst[k] = 0; mval[k] = 0;
      end else begin
         pop = (mn[k] >= s);
         if (pop) begin
            v = 0;
            for (int i = 0; i < s; i++)
               if (mb[k][i]) v |= mm[k] ? (1 << (s - 1 - i)) : (1 << i);
            for (int i = 0; i < 64 - s; i++) mb[k][i] = mb[k][i + s];
            mn[k] -= s;
            mval[k] = 1; mdat[k] = v; mcnt[k]++; mst[k] = 1;
         end else begin
            mval[k] = 0;
            if (mst[k] && mund[k] < 65535) mund[k]++;
         end
         if (word_valid && mn[k] + 16 <= 16 + 2 * s) begin
            push = 1'b1;
            for (int j = 0; j < 16; j++)
               mb[k][mn[k] + j] = mm[k] ? word_data[15 - j] : word_data[j];
            mn[k] += 16;
         end
      end
      if (k == 2 && push) mrd_c++;
      check({nm[k], ".word_rd"}, rdv[k], push);
   endtask

   task automatic step(input bit v, input logic [15:0] d, input bit fl,
                       input bit hl, input bit rs);
      word_valid = v; word_data = d; flush = fl; halt = hl; reset = rs;
      #1;
      if (rd_c) rd_c_seen++;
      for (int k = 0; k < 3; k++) model_cycle(k);
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 3; k++) begin
         check({nm[k], ".sample_valid"}, svv[k], mval[k]);
         check({nm[k], ".sample_data"}, sdv[k], mdat[k]);
         check({nm[k], ".fill_level"}, flv[k], mn[k]);
         check({nm[k], ".sample_count"}, scv[k], mcnt[k]);
         check({nm[k], ".underrun_count"}, ucv[k], mund[k]);
         if (svv[k]) begin
            if (k == 0) logA.push_back(int'(sdv[k]));
            else if (k == 1) logB.push_back(int'(sdv[k]));
            else begin
               logC.push_back(int'(sdv[k]));
               ccyc.push_back(cyc);
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 16'h0, 0, 0, 0);
   endtask

   task automatic clear_logs();
      logA.delete(); logB.delete(); logC.delete(); ccyc.delete();
      rd_c_seen = 0; mrd_c = 0;
   endtask

   int e_lsb [4] = '{4, 3, 2, 1};
   int e_msb [4] = '{1, 2, 3, 4};
   int e_fl  [6] = '{4, 3, 13, 12, 11, 10};
   int sevens;

   initial begin
      @(negedge clk);
      step(0, 16'h0, 0, 0, 1);
      step(0, 16'h0, 0, 0, 1);
      check("reset.A.fill", flv[0], 0);
      check("reset.C.valid", svv[2], 0);

      // Single word, both bit orders.
      clear_logs();
      step(1, 16'h1234, 0, 0, 0);
      idle(8);
      check("t1.A.len", logA.size(), 4);
      check("t1.B.len", logB.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("t1.A.seq", (i < logA.size()) ? logA[i] : 99, e_lsb[i]);
         check("t1.B.seq", (i < logB.size()) ? logB[i] : 99, e_msb[i]);
      end
      check("t1.A.count", scv[0], 4);
      check("t1.A.underrun", ucv[0], 4);

      // Three all-ones words back to back into the 3-bit unpacker.
      step(0, 16'h0, 0, 0, 1);
      clear_logs();
      for (int i = 0; i < 40 && mrd_c < 3; i++) step(1, 16'hFFFF, 0, 0, 0);
      idle(20);
      check("t3.C.rd_count", rd_c_seen, 3);
      check("t3.C.len", logC.size(), 16);
      sevens = 0;
      foreach (logC[i]) if (logC[i] == 7) sevens++;
      check("t3.C.sevens", sevens, 16);
      check("t3.C.span", (ccyc.size() == 16) ? ccyc[15] - ccyc[0] : -1, 15);
      check("t3.C.fill", flv[2], 0);

      // Flush discards the upper byte of the first word.
      step(0, 16'h0, 0, 0, 1);
      clear_logs();
      step(1, 16'h1234, 0, 0, 0);
      idle(2);
      step(0, 16'h0, 1, 0, 0);
      step(1, 16'hABCD, 0, 0, 0);
      check("t4.A.underrun", ucv[0], 0);
      idle(7);
      check("t4.A.len", logA.size(), 6);
      for (int i = 0; i < 6; i++)
         check("t4.A.seq", (i < logA.size()) ? logA[i] : 99, e_fl[i]);

      // Halt mid-stream with word_valid held high.
      step(0, 16'h0, 0, 0, 1);
      for (int i = 0; i < 12; i++) step(1, 16'($urandom), 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 16'($urandom), 0, 1, 0);
         check("t5.C.halt_valid", svv[2], 0);
      end
      for (int i = 0; i < 12; i++) step(1, 16'($urandom), 0, 0, 0);

      // Reset while the 3-bit unpacker holds 7 bits.
      for (int i = 0; i < 50 && mn[2] != 7; i++) step(1, 16'($urandom), 0, 0, 0);
      check("t6.C.fill_pre", flv[2], 7);
      step(1, 16'($urandom), 0, 0, 1);
      check("t6.C.fill", flv[2], 0);
      check("t6.C.valid", svv[2], 0);
      check("t6.C.count", scv[2], 0);
      check("t6.C.underrun", ucv[2], 0);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 9) < 7, 16'($urandom),
              $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6,
              $urandom_range(0, 199) < 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
